// File: rtl/imm_enc.sv
// RISC-V immediate encoder: merges an immediate into an instruction template,
// and expands load-immediate requests into ADDI or LUI+ADDI.
module imm_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        fit12, fit13, fit21;
  logic [4:0]  rd;
  logic [19:0] hi;
  logic [31:0] lo_inst;
  logic [31:0] enc_inst;
  logic        enc_err, enc_last, enc_two;
  logic [31:0] pend_inst;

  // Handshake: a word is transferred on a rising edge where valid and ready
  // are both 1; out_* are held stable while out_valid=1 and out_ready=0.
  assign in_ready  = rst_n & (state == IDLE) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign dbg_state = (state == LI_LO);

  // Signed-range checks: the bits above the field's sign bit must all match it.
  assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  assign rd      = in_base[11:7];
  // Rounds so the sign-extended ADDI low part brings the LUI value back to imm.
  assign hi      = in_imm[31:12] + {19'd0, in_imm[11]};
  assign lo_inst = {in_imm[11:0], rd, 3'b000, rd, 7'h13};

  always_comb begin
    enc_inst = in_base;
    enc_err  = 1'b0;
    enc_last = 1'b1;
    enc_two  = 1'b0;
    case (in_sel)
      3'd0: begin
        enc_inst[31:20] = in_imm[11:0];
        enc_err         = ~fit12;
      end
      3'd1: begin
        enc_inst[31:25] = in_imm[11:5];
        enc_inst[11:7]  = in_imm[4:0];
        enc_err         = ~fit12;
      end
      3'd2: begin
        enc_inst[31]    = in_imm[12];
        enc_inst[30:25] = in_imm[10:5];
        enc_inst[11:8]  = in_imm[4:1];
        enc_inst[7]     = in_imm[11];
        enc_err         = ~fit13 | in_imm[0];
      end
      3'd3: begin
        enc_inst[31:12] = in_imm[31:12];
        enc_err         = |in_imm[11:0];
      end
      3'd4: begin
        enc_inst[31]    = in_imm[20];
        enc_inst[30:21] = in_imm[10:1];
        enc_inst[20]    = in_imm[11];
        enc_inst[19:12] = in_imm[19:12];
        enc_err         = ~fit21 | in_imm[0];
      end
      3'd5: begin
        if (fit12) begin
          enc_inst = {in_imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          enc_inst = {hi, rd, 7'h37};
          enc_two  = |in_imm[11:0];
          enc_last = ~(|in_imm[11:0]);
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept && enc_two) state_nx = LI_LO;
      LI_LO: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
      pend_inst <= 32'd0;
    end else if (state == LI_LO) begin
      if (out_ready) begin
        out_inst <= pend_inst;
        out_err  <= 1'b0;
        out_last <= 1'b1;
      end
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst;
      out_err   <= enc_err;
      out_last  <= enc_last;
      if (enc_two) pend_inst <= lo_inst;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/imm_enc.md
IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, request present.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-005 SHALL have port in_sel, input, 3, encoding: 0=I, 1=S, 2=B, 3=U, 4=J, 5=LI (load-immediate expansion), 6-7 illegal.
REQ-006 SHALL have port in_base, input, 32, instruction template; immediate bit positions are overwritten, all other bits pass through.
REQ-007 SHALL have port in_imm, input, 32, two's-complement immediate value (byte offset for B/J).
REQ-008 SHALL have port out_valid, output, 1, out_inst holds a valid instruction word.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid and out_ready are both 1 on a rising edge.
REQ-010 SHALL have port out_inst, output, 32, encoded instruction word.
REQ-011 SHALL have port out_err, output, 1, range, alignment or select violation for this word.
REQ-012 SHALL have port out_last, output, 1, final word of the current request.

Function
REQ-013 SHALL encode I-type as inst[31:20]=imm[11:0]; err if imm is not in -2048..2047.
REQ-014 SHALL encode S-type as inst[31:25]=imm[11:5] and inst[11:7]=imm[4:0]; err if imm is not in -2048..2047.
REQ-015 SHALL encode B-type as inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]; err if imm is not in -4096..4094 or imm[0]=1.
REQ-016 SHALL encode U-type as inst[31:12]=imm[31:12]; err if imm[11:0] is not 0.
REQ-017 SHALL encode J-type as inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; err if imm is not in -1048576..1048574 or imm[0]=1.
REQ-018 SHALL, on err for types I/S/B/U/J, still emit the truncated-field encoding with out_err=1.
REQ-019 SHALL, for sel 6/7, emit in_base unchanged with out_err=1 and out_last=1.
REQ-020 SHALL, for LI, take rd=in_base[11:7], ignore other in_base bits, and never assert out_err.
REQ-021 SHALL, for LI with imm in -2048..2047, emit one word ADDI rd,x0,imm = {imm[11:0],5'd0,3'b000,rd,7'h13}.
REQ-022 SHALL, for LI otherwise, compute hi=(imm+32'h800)[31:12], emit LUI {hi,rd,7'h37}, then ADDI rd,rd,imm[11:0] = {imm[11:0],rd,3'b000,rd,7'h13}.
REQ-023 SHALL, when the LI LUI path has imm[11:0]=0, emit the LUI only, with out_last=1.
REQ-024 SHALL assert out_last=1 on every single-word result and on the ADDI of a two-word LI.
REQ-025 SHALL use FSM states IDLE and LI_LO; LI_LO is entered when a two-word LI request is accepted, and is left for IDLE when the LUI word is consumed, at which point the ADDI word loads into the output register.
REQ-026 SHALL register the output with a latency of 1 cycle from acceptance to out_valid=1.
REQ-027 SHALL drive in_ready = (state==IDLE) & (!out_valid | out_ready), giving a throughput of 1 request/cycle while out_ready=1.
REQ-028 SHALL hold out_inst, out_err and out_last stable while out_valid=1 and out_ready=0.
REQ-029 SHALL hold in_ready=0 for the whole of LI_LO.
REQ-030 SHALL drop out_valid after a consumed final word when no new request is accepted in the same cycle.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, out_valid=0, out_inst=0, out_err=0, out_last=0 and in_ready=0, taking effect immediately and without waiting for clk.
REQ-032 SHALL, on reset mid-LI, discard the pending ADDI with no word emitted after reset.
REQ-033 SHALL assert in_ready on the first cycle after rst_n deasserts.

Verification
REQ-034 SHALL cover B-type: sel=2, imm=0xFFFFFFF8, base=0x00000063 -> out_inst=0xFE000CE3, out_err=0, out_last=1, one cycle after acceptance.
REQ-035 SHALL cover two-word LI: sel=5, imm=0x12345678, base=0x00000280 -> 0x123452B7 (last=0), then 0x67828293 (last=1); in_ready=0 between the two words.
REQ-036 SHALL cover the LI rounding boundary: imm=0x00000800, rd=1 -> 0x000010B7, 0x80008093. imm=0xFFFFF800, rd=1 -> single word 0x80000093. imm=0x00003000, rd=1 -> single word 0x000030B7.
REQ-037 SHALL cover range errors: sel=0, imm=0x800 -> out_err=1. sel=4, imm=0x00100000 -> out_err=1. sel=2, imm=0x3 -> out_err=1. sel=6 -> out_inst=in_base, out_err=1.
REQ-038 SHALL cover backpressure: out_ready=0 for 3 cycles with a word pending -> out_* stable and in_ready=0; then out_ready=1 with back-to-back requests -> 1 word/cycle.
REQ-039 SHALL cover reset in LI_LO: after the LUI is emitted, pulse rst_n=0 -> out_valid=0 immediately, no ADDI emitted, in_ready=1 after release.
